// File: rtl/gemm_pkg.sv
// Shared types and helpers for the tiled GeMM core: FSM state encoding,
// ceiling division and element-packing index helpers for the A, B and C words.
package gemm_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

   // Flat element index of (r, c) inside a C tile word
   function automatic int elem_idx(input int r, input int c, input int col_par);
      return r * col_par + c;
   endfunction

   function automatic int elem_lsb(input int r, input int c, input int col_par, input int width);
      return elem_idx(r, c, col_par) * width;
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/gemm_tile_ctrl.sv
// Tile-loop FSM: walks (mt, nt, k), issues A/B reads, sequences accumulate/write
// and produces the ragged-edge mask. The C write holds until c_ready; no reads stall.
module gemm_tile_ctrl
   import gemm_pkg::*;
#(
   parameter int AddrWidth     = 16,
   parameter int SizeAddrWidth = 8,
   parameter int RowPar        = 4,
   parameter int ColPar        = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        start,
   input  logic [SizeAddrWidth-1:0]    m_size,
   input  logic [SizeAddrWidth-1:0]    k_size,
   input  logic [SizeAddrWidth-1:0]    n_size,
   input  logic                        c_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        re,
   output logic [AddrWidth-1:0]        a_addr,
   output logic [AddrWidth-1:0]        b_addr,
   output logic [AddrWidth-1:0]        c_addr,
   output logic                        c_valid,
   output logic                        acc_en,
   output logic                        acc_first,
   output logic [RowPar*ColPar-1:0]    mask
);

   localparam logic [SizeAddrWidth-1:0] SizeOne = SizeAddrWidth'(1);

   state_t state_q, state_d;

   logic [SizeAddrWidth-1:0] m_q, n_q, k_q, k_last_q;
   logic [SizeAddrWidth-1:0] mt_last_q, nt_last_q, nt_tiles_q;
   logic [SizeAddrWidth-1:0] mt_q, nt_q, k_cnt_q, k_d_q;
   logic                     vld_d_q;
   logic                     size_zero, last_tile;

   assign size_zero = (m_size == '0) || (k_size == '0) || (n_size == '0);
   assign last_tile = (mt_q == mt_last_q) && (nt_q == nt_last_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = size_zero ? DONE : FETCH;
         FETCH:   if (k_cnt_q == k_last_q) state_d = DRAIN;
         DRAIN:   state_d = WRITE;
         WRITE:   if (c_ready) state_d = last_tile ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_q        <= '0;
         n_q        <= '0;
         k_q        <= '0;
         k_last_q   <= '0;
         mt_last_q  <= '0;
         nt_last_q  <= '0;
         nt_tiles_q <= '0;
         mt_q       <= '0;
         nt_q       <= '0;
         k_cnt_q    <= '0;
         k_d_q      <= '0;
         vld_d_q    <= 1'b0;
      end else begin
         // Read data arrives one cycle after re; k travels with it
         vld_d_q <= (state_q == FETCH);
         k_d_q   <= k_cnt_q;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  m_q        <= m_size;
                  n_q        <= n_size;
                  k_q        <= k_size;
                  k_last_q   <= k_size - SizeOne;
                  mt_last_q  <= SizeAddrWidth'(ceil_div(32'(m_size), RowPar) - 1);
                  nt_last_q  <= SizeAddrWidth'(ceil_div(32'(n_size), ColPar) - 1);
                  nt_tiles_q <= SizeAddrWidth'(ceil_div(32'(n_size), ColPar));
                  mt_q       <= '0;
                  nt_q       <= '0;
                  k_cnt_q    <= '0;
               end
            end
            FETCH: begin
               k_cnt_q <= (k_cnt_q == k_last_q) ? '0 : k_cnt_q + SizeOne;
            end
            WRITE: begin
               if (c_ready && !last_tile) begin
                  if (nt_q == nt_last_q) begin
                     nt_q <= '0;
                     mt_q <= mt_q + SizeOne;
                  end else begin
                     nt_q <= nt_q + SizeOne;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      re        = (state_q == FETCH);
      c_valid   = (state_q == WRITE);
      acc_en    = vld_d_q;
      acc_first = (k_d_q == '0);
      a_addr    = '0;
      b_addr    = '0;
      c_addr    = '0;
      mask      = '0;
      if (re) begin
         a_addr = AddrWidth'(mt_q) * AddrWidth'(k_q) + AddrWidth'(k_cnt_q);
         b_addr = AddrWidth'(nt_q) * AddrWidth'(k_q) + AddrWidth'(k_cnt_q);
      end
      if (c_valid) begin
         c_addr = AddrWidth'(mt_q) * AddrWidth'(nt_tiles_q) + AddrWidth'(nt_q);
         for (int r = 0; r < RowPar; r++) begin
            for (int c = 0; c < ColPar; c++) begin
               mask[elem_idx(r, c, ColPar)] =
                  ((int'(mt_q) * RowPar + r) < int'(m_q)) &&
                  ((int'(nt_q) * ColPar + c) < int'(n_q));
            end
         end
      end
   end

endmodule

// File: rtl/gemm_tiled_array.sv
// Output-stationary RowPar x ColPar signed MAC array; a tile takes K+2 cycles.
// The C write is held stable while sram_c_ready_i is low; reads pause meanwhile.
module gemm_tiled_array
   import gemm_pkg::*;
#(
   parameter int InDataWidth   = 8,
   parameter int OutDataWidth  = 32,
   parameter int AddrWidth     = 16,
   parameter int SizeAddrWidth = 8,
   parameter int RowPar        = 4,
   parameter int ColPar        = 16
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    start_i,
   input  logic [SizeAddrWidth-1:0]                M_size_i,
   input  logic [SizeAddrWidth-1:0]                K_size_i,
   input  logic [SizeAddrWidth-1:0]                N_size_i,
   output logic                                    busy_o,
   output logic                                    done_o,
   output logic [AddrWidth-1:0]                    sram_a_addr_o,
   output logic                                    sram_a_re_o,
   input  logic [RowPar*InDataWidth-1:0]           sram_a_rdata_i,
   output logic [AddrWidth-1:0]                    sram_b_addr_o,
   output logic                                    sram_b_re_o,
   input  logic [ColPar*InDataWidth-1:0]           sram_b_rdata_i,
   output logic [AddrWidth-1:0]                    sram_c_addr_o,
   output logic [RowPar*ColPar*OutDataWidth-1:0]   sram_c_wdata_o,
   output logic [RowPar*ColPar-1:0]                sram_c_mask_o,
   output logic                                    sram_c_valid_o,
   input  logic                                    sram_c_ready_i
);

   logic                      re, acc_en, acc_first, c_valid;
   logic [RowPar*ColPar-1:0]  mask;

   gemm_tile_ctrl #(
      .AddrWidth     (AddrWidth),
      .SizeAddrWidth (SizeAddrWidth),
      .RowPar        (RowPar),
      .ColPar        (ColPar)
   ) u_ctrl (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start     (start_i),
      .m_size    (M_size_i),
      .k_size    (K_size_i),
      .n_size    (N_size_i),
      .c_ready   (sram_c_ready_i),
      .busy      (busy_o),
      .done      (done_o),
      .re        (re),
      .a_addr    (sram_a_addr_o),
      .b_addr    (sram_b_addr_o),
      .c_addr    (sram_c_addr_o),
      .c_valid   (c_valid),
      .acc_en    (acc_en),
      .acc_first (acc_first),
      .mask      (mask)
   );

   assign sram_a_re_o    = re;
   assign sram_b_re_o    = re;
   assign sram_c_valid_o = c_valid;
   assign sram_c_mask_o  = mask;

   for (genvar r = 0; r < RowPar; r++) begin : g_row
      for (genvar c = 0; c < ColPar; c++) begin : g_col
         logic signed [InDataWidth-1:0]    a_el, b_el;
         logic signed [2*InDataWidth-1:0]  prod;
         logic signed [OutDataWidth-1:0]   prod_ext, acc_q;

         assign a_el     = sram_a_rdata_i[lane_lsb(r, InDataWidth) +: InDataWidth];
         assign b_el     = sram_b_rdata_i[lane_lsb(c, InDataWidth) +: InDataWidth];
         assign prod     = a_el * b_el;
         assign prod_ext = OutDataWidth'(prod);

         // First beat of a tile overwrites, so no clear bubble between tiles
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               acc_q <= '0;
            end else if (acc_en) begin
               acc_q <= acc_first ? prod_ext : acc_q + prod_ext;
            end
         end

         assign sram_c_wdata_o[elem_lsb(r, c, ColPar, OutDataWidth) +: OutDataWidth] =
            (c_valid && mask[elem_idx(r, c, ColPar)]) ? acc_q : '0;
      end
   end

endmodule

// File: tb/tb_gemm_tiled_array.sv
// Randomized bench for gemm_tiled_array with a matrix-level reference model.
module tb_gemm_tiled_array;

   localparam int RP = 4;
   localparam int CP = 16;
   localparam int NE = RP * CP;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start32, start16, c_ready;
   logic [7:0] m_size, k_size, n_size;

   logic              busy32, done32, a_re32, b_re32, c_valid32;
   logic [15:0]       a_addr32, b_addr32, c_addr32;
   logic [31:0]       a_rd32;
   logic [127:0]      b_rd32;
   logic [NE*32-1:0]  c_wdata32;
   logic [NE-1:0]     c_mask32;

   logic              busy16, done16, a_re16, b_re16, c_valid16;
   logic [15:0]       a_addr16, b_addr16, c_addr16;
   logic [31:0]       a_rd16;
   logic [127:0]      b_rd16;
   logic [NE*16-1:0]  c_wdata16;
   logic [NE-1:0]     c_mask16;

   gemm_tiled_array u_dut32 (
      .clk_i(clk), .rst_i(rst), .start_i(start32),
      .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
      .busy_o(busy32), .done_o(done32),
      .sram_a_addr_o(a_addr32), .sram_a_re_o(a_re32), .sram_a_rdata_i(a_rd32),
      .sram_b_addr_o(b_addr32), .sram_b_re_o(b_re32), .sram_b_rdata_i(b_rd32),
      .sram_c_addr_o(c_addr32), .sram_c_wdata_o(c_wdata32), .sram_c_mask_o(c_mask32),
      .sram_c_valid_o(c_valid32), .sram_c_ready_i(c_ready)
   );

   gemm_tiled_array #(.OutDataWidth(16)) u_dut16 (
      .clk_i(clk), .rst_i(rst), .start_i(start16),
      .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
      .busy_o(busy16), .done_o(done16),
      .sram_a_addr_o(a_addr16), .sram_a_re_o(a_re16), .sram_a_rdata_i(a_rd16),
      .sram_b_addr_o(b_addr16), .sram_b_re_o(b_re16), .sram_b_rdata_i(b_rd16),
      .sram_c_addr_o(c_addr16), .sram_c_wdata_o(c_wdata16), .sram_c_mask_o(c_mask16),
      .sram_c_valid_o(c_valid16), .sram_c_ready_i(c_ready)
   );

   // Matrices in plain math form, plus the SRAM images built from them
   int           a_mat [0:15][0:7];
   int           b_mat [0:7][0:47];
   logic [31:0]  a_mem [0:255];
   logic [127:0] b_mem [0:255];

   always @(posedge clk) begin
      if (a_re32) a_rd32 <= a_mem[a_addr32[7:0]];
      if (b_re32) b_rd32 <= b_mem[b_addr32[7:0]];
      if (a_re16) a_rd16 <= a_mem[a_addr16[7:0]];
      if (b_re16) b_rd16 <= b_mem[b_addr16[7:0]];
   end

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0]      wr_addr_q [$];
   logic [NE*32-1:0] wr_data_q [$];
   logic [NE-1:0]    wr_mask_q [$];
   int done_cyc, first_re, first_vld, re_cnt, vld_cnt;
   bit re_in_write, unstable, timed_out;

   task automatic fill_const(input int av, input int bv);
      for (int i = 0; i < 16; i++) for (int k = 0; k < 8; k++) a_mat[i][k] = av;
      for (int k = 0; k < 8; k++) for (int j = 0; j < 48; j++) b_mat[k][j] = bv;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 16; i++) for (int k = 0; k < 8; k++) a_mat[i][k] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < 8; k++) for (int j = 0; j < 48; j++) b_mat[k][j] = int'($urandom_range(255)) - 128;
   endtask

   // Padding lanes get junk so masking of ragged edges is exercised
   task automatic load_mem(input int M, input int K, input int N);
      int mt_n, nt_n, idx;
      mt_n = (M + RP - 1) / RP;
      nt_n = (N + CP - 1) / CP;
      for (int mt = 0; mt < mt_n; mt++) for (int k = 0; k < K; k++) begin
         idx = mt * K + k;
         for (int r = 0; r < RP; r++)
            a_mem[idx][r*8 +: 8] = (mt*RP + r < M) ? 8'(a_mat[mt*RP + r][k]) : 8'($urandom_range(255));
      end
      for (int nt = 0; nt < nt_n; nt++) for (int k = 0; k < K; k++) begin
         idx = nt * K + k;
         for (int c = 0; c < CP; c++)
            b_mem[idx][c*8 +: 8] = (nt*CP + c < N) ? 8'(b_mat[k][nt*CP + c]) : 8'($urandom_range(255));
      end
   endtask

   function automatic int expect_elem(input int M, input int K, input int N,
                                      input int mt, input int nt, input int r, input int c, input int w);
      longint s, modv;
      int m, n;
      m = mt * RP + r;
      n = nt * CP + c;
      if (m >= M || n >= N) return 0;
      s = 0;
      for (int k = 0; k < K; k++) s += longint'(a_mat[m][k]) * longint'(b_mat[k][n]);
      modv = longint'(1) << w;
      s = s & (modv - 1);
      if (s >= modv / 2) s -= modv;
      return int'(s);
   endfunction

   // Starts an operation in cycle 0 and records every accepted C write
   task automatic run_op(input int M, input int K, input int N, input int stall, input bit sel);
      int cyc, stall_left;
      bit prev_stalled, re, vld, dn;
      logic [15:0] addr, p_addr;
      logic [NE-1:0] mask, p_mask;
      logic [NE*32-1:0] data, p_data;
      wr_addr_q.delete(); wr_data_q.delete(); wr_mask_q.delete();
      done_cyc = -1; first_re = -1; first_vld = -1; re_cnt = 0; vld_cnt = 0;
      re_in_write = 0; unstable = 0; timed_out = 0;
      prev_stalled = 0; stall_left = stall; p_addr = '0; p_mask = '0; p_data = '0;
      @(negedge clk);
      m_size = 8'(M); k_size = 8'(K); n_size = 8'(N);
      start32 = !sel; start16 = sel; c_ready = 1'b1;
      cyc = 0;
      forever begin
         @(negedge clk);
         start32 = 1'b0; start16 = 1'b0;
         cyc++;
         if (sel) begin
            re = a_re16; vld = c_valid16; dn = done16; addr = c_addr16; mask = c_mask16;
            for (int e = 0; e < NE; e++) data[e*32 +: 32] = {{16{c_wdata16[e*16+15]}}, c_wdata16[e*16 +: 16]};
         end else begin
            re = a_re32; vld = c_valid32; dn = done32; addr = c_addr32; mask = c_mask32; data = c_wdata32;
         end
         if (re) begin re_cnt++; if (first_re < 0) first_re = cyc; end
         if (vld) begin
            vld_cnt++;
            if (first_vld < 0) first_vld = cyc;
            if (re) re_in_write = 1;
            if (prev_stalled && (addr !== p_addr || data !== p_data || mask !== p_mask)) unstable = 1;
            if (stall_left > 0) begin
               c_ready = 1'b0; stall_left--; prev_stalled = 1;
               p_addr = addr; p_data = data; p_mask = mask;
            end else begin
               c_ready = 1'b1; prev_stalled = 0;
               wr_addr_q.push_back(addr); wr_data_q.push_back(data); wr_mask_q.push_back(mask);
            end
         end else begin
            c_ready = 1'b1; prev_stalled = 0;
         end
         if (dn) begin done_cyc = cyc; break; end
         if (cyc > 3000) begin timed_out = 1; break; end
      end
      c_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start32 = 0; start16 = 0; c_ready = 1'b1;
      m_size = '0; k_size = '0; n_size = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({busy32, done32, a_re32, b_re32, c_valid32, busy16, done16, c_valid16} !== 8'b0) begin
         tests_failed++; $display("FAIL reset_ctrl: got %b want 0", {busy32, done32, a_re32, b_re32, c_valid32, busy16, done16, c_valid16});
      end
      tests_run++;
      if ({a_addr32, b_addr32, c_addr32} !== 48'h0) begin
         tests_failed++; $display("FAIL reset_addr: got %h want 0", {a_addr32, b_addr32, c_addr32});
      end
      tests_run++;
      if (c_wdata32 !== '0 || c_mask32 !== '0) begin
         tests_failed++; $display("FAIL reset_c: mask %h want 0, wdata nonzero=%0d", c_mask32, c_wdata32 != '0);
      end
   endtask

   task automatic test_basic();
      int bad;
      fill_const(1, 2);
      load_mem(4, 3, 16);
      run_op(4, 3, 16, 0, 0);
      tests_run++;
      if (timed_out || done_cyc != 6) begin
         tests_failed++; $display("FAIL basic_done_cycle: got %0d want 6", done_cyc);
      end
      tests_run++;
      if (first_re != 1 || re_cnt != 3 || first_vld != 5) begin
         tests_failed++; $display("FAIL basic_timing: re %0d x%0d valid %0d want 1 x3 5", first_re, re_cnt, first_vld);
      end
      tests_run++;
      if (wr_addr_q.size() != 1) begin
         tests_failed++; $display("FAIL basic_writes: got %0d want 1", wr_addr_q.size());
      end else begin
         tests_run++;
         if (wr_addr_q[0] !== 16'd0 || wr_mask_q[0] !== {NE{1'b1}}) begin
            tests_failed++; $display("FAIL basic_addr_mask: addr %0d mask %h want 0 all-ones", wr_addr_q[0], wr_mask_q[0]);
         end
         bad = -1;
         for (int e = 0; e < NE; e++) if (bad < 0 && wr_data_q[0][e*32 +: 32] !== 32'd6) bad = e;
         tests_run++;
         if (bad >= 0) begin
            tests_failed++; $display("FAIL basic_data: elem %0d got %0d want 6", bad, $signed(wr_data_q[0][bad*32 +: 32]));
         end
      end
   endtask

   task automatic test_ragged();
      int bad, mt, nt, r, c;
      logic [NE-1:0] exp_mask;
      logic [31:0] exp_v;
      fill_rand();
      load_mem(5, 2, 17);
      run_op(5, 2, 17, 0, 0);
      tests_run++;
      if (timed_out || done_cyc != 17 || wr_addr_q.size() != 4) begin
         tests_failed++; $display("FAIL ragged_count: writes %0d done %0d want 4 17", wr_addr_q.size(), done_cyc);
      end else begin
         for (int i = 0; i < 4; i++) begin
            mt = i / 2; nt = i % 2;
            for (int e = 0; e < NE; e++) exp_mask[e] = (mt*RP + e/CP < 5) && (nt*CP + e%CP < 17);
            tests_run++;
            if (wr_addr_q[i] !== 16'(i) || wr_mask_q[i] !== exp_mask) begin
               tests_failed++; $display("FAIL ragged_addr_mask[%0d]: addr %0d mask %h want %0d %h", i, wr_addr_q[i], wr_mask_q[i], i, exp_mask);
            end
            bad = -1; exp_v = '0;
            for (int e = 0; e < NE; e++) begin
               r = e / CP; c = e % CP;
               if (bad < 0 && wr_data_q[i][e*32 +: 32] !== 32'(expect_elem(5, 2, 17, mt, nt, r, c, 32))) begin
                  bad = e; exp_v = 32'(expect_elem(5, 2, 17, mt, nt, r, c, 32));
               end
            end
            tests_run++;
            if (bad >= 0) begin
               tests_failed++; $display("FAIL ragged_data[%0d]: elem %0d got %h want %h", i, bad, wr_data_q[i][bad*32 +: 32], exp_v);
            end
         end
         tests_run++;
         if (wr_mask_q[3] !== 64'h1) begin
            tests_failed++; $display("FAIL ragged_corner_mask: got %h want 1", wr_mask_q[3]);
         end
      end
   endtask

   task automatic test_back_pressure();
      int bad;
      fill_const(1, 2);
      load_mem(4, 3, 16);
      run_op(4, 3, 16, 5, 0);
      tests_run++;
      if (timed_out || done_cyc != 11) begin
         tests_failed++; $display("FAIL bp_done_cycle: got %0d want 11", done_cyc);
      end
      tests_run++;
      if (unstable || re_in_write || vld_cnt != 6) begin
         tests_failed++; $display("FAIL bp_hold: unstable %0d re_in_write %0d valid cycles %0d want 0 0 6", unstable, re_in_write, vld_cnt);
      end
      bad = -1;
      if (wr_data_q.size() == 1)
         for (int e = 0; e < NE; e++) if (bad < 0 && wr_data_q[0][e*32 +: 32] !== 32'd6) bad = e;
      tests_run++;
      if (wr_data_q.size() != 1 || bad >= 0) begin
         tests_failed++; $display("FAIL bp_data: writes %0d bad elem %0d want 1 write all 6", wr_data_q.size(), bad);
      end
   endtask

   task automatic test_signed_wrap();
      int bad;
      fill_const(-128, -128);
      load_mem(4, 2, 16);
      run_op(4, 2, 16, 0, 1);
      bad = -1;
      if (wr_data_q.size() == 1)
         for (int e = 0; e < NE; e++) if (bad < 0 && wr_data_q[0][e*32 +: 32] !== 32'hFFFF_8000) bad = e;
      tests_run++;
      if (timed_out || wr_data_q.size() != 1 || bad >= 0) begin
         tests_failed++; $display("FAIL wrap16: writes %0d bad elem %0d want all -32768", wr_data_q.size(), bad);
      end
      run_op(4, 2, 16, 0, 0);
      bad = -1;
      if (wr_data_q.size() == 1)
         for (int e = 0; e < NE; e++) if (bad < 0 && wr_data_q[0][e*32 +: 32] !== 32'd32768) bad = e;
      tests_run++;
      if (timed_out || wr_data_q.size() != 1 || bad >= 0) begin
         tests_failed++; $display("FAIL nowrap32: writes %0d bad elem %0d want all 32768", wr_data_q.size(), bad);
      end
      fill_const(-3, 7);
      load_mem(4, 4, 16);
      run_op(4, 4, 16, 0, 1);
      bad = -1;
      if (wr_data_q.size() == 1)
         for (int e = 0; e < NE; e++) if (bad < 0 && $signed(wr_data_q[0][e*32 +: 32]) != -84) bad = e;
      tests_run++;
      if (timed_out || wr_data_q.size() != 1 || bad >= 0) begin
         tests_failed++; $display("FAIL mixed_sign16: writes %0d bad elem %0d want all -84", wr_data_q.size(), bad);
      end
   endtask

   task automatic test_zero_size();
      int dims [3][3];
      dims = '{'{4, 0, 4}, '{0, 3, 4}, '{4, 3, 0}};
      for (int i = 0; i < 3; i++) begin
         run_op(dims[i][0], dims[i][1], dims[i][2], 0, 0);
         tests_run++;
         if (timed_out || done_cyc != 1 || re_cnt != 0 || vld_cnt != 0) begin
            tests_failed++;
            $display("FAIL zero_size[%0d]: done %0d re %0d valid %0d want 1 0 0", i, done_cyc, re_cnt, vld_cnt);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int bad, seen_valid;
      logic [31:0] exp_v;
      fill_rand();
      load_mem(8, 4, 16);
      @(negedge clk);
      m_size = 8'd8; k_size = 8'd4; n_size = 8'd16; start32 = 1'b1; c_ready = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         start32 = 1'b0;
      end
      tests_run++;
      if (a_re32 !== 1'b1 || a_addr32 !== 16'd5) begin
         tests_failed++; $display("FAIL midop_fetch: re %b addr %0d want 1 5", a_re32, a_addr32);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (busy32 !== 1'b0 || a_re32 !== 1'b0 || c_valid32 !== 1'b0 || done32 !== 1'b0 ||
          a_addr32 !== 16'd0 || b_addr32 !== 16'd0 || c_addr32 !== 16'd0 ||
          c_wdata32 !== '0 || c_mask32 !== '0) begin
         tests_failed++; $display("FAIL midop_reset_outputs: busy %b re %b valid %b addr %0d want 0", busy32, a_re32, c_valid32, a_addr32);
      end
      seen_valid = 0;
      repeat (10) begin
         @(negedge clk);
         if (c_valid32 || busy32) seen_valid++;
      end
      tests_run++;
      if (seen_valid != 0) begin
         tests_failed++; $display("FAIL midop_quiet: active cycles %0d want 0", seen_valid);
      end
      run_op(8, 4, 16, 0, 0);
      tests_run++;
      if (timed_out || done_cyc != 13 || wr_addr_q.size() != 2) begin
         tests_failed++; $display("FAIL midop_rerun: writes %0d done %0d want 2 13", wr_addr_q.size(), done_cyc);
      end else begin
         for (int i = 0; i < 2; i++) begin
            bad = -1; exp_v = '0;
            for (int e = 0; e < NE; e++)
               if (bad < 0 && wr_data_q[i][e*32 +: 32] !== 32'(expect_elem(8, 4, 16, i, 0, e / CP, e % CP, 32))) begin
                  bad = e; exp_v = 32'(expect_elem(8, 4, 16, i, 0, e / CP, e % CP, 32));
               end
            tests_run++;
            if (wr_addr_q[i] !== 16'(i) || bad >= 0) begin
               tests_failed++; $display("FAIL midop_data[%0d]: addr %0d elem %0d got %h want %h", i, wr_addr_q[i], bad,
                                        (bad >= 0) ? wr_data_q[i][bad*32 +: 32] : 32'h0, exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ragged();
      test_back_pressure();
      test_signed_wrap();
      test_zero_size();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
